// File: rtl/icache_dm_ctrl_pkg.sv
// Shared definitions for the direct-mapped instruction cache and its DRAM model:
// FSM state encoding and line geometry derivation.
package icache_dm_ctrl_pkg;

  localparam int unsigned ByteOffsetBits = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StUpdate
  } state_e;

  function automatic int unsigned nb_words_line(input int unsigned byte_offset_bits);
    return (2 ** byte_offset_bits) / 4;
  endfunction

  function automatic int unsigned line_size(input int unsigned byte_offset_bits);
    return 32 * nb_words_line(byte_offset_bits);
  endfunction

  localparam int unsigned NbWordsLine = nb_words_line(ByteOffsetBits);
  localparam int unsigned LineSize    = line_size(ByteOffsetBits);

endpackage

// File: rtl/icache_dm_ctrl_line_store.sv
// Tag, valid and data storage for the direct-mapped cache: asynchronous read,
// synchronous write, bulk valid clear.
module icache_line_store #(
  parameter int unsigned NbLines   = 16,
  parameter int unsigned IndexBits = 4,
  parameter int unsigned TagBits   = 23,
  parameter int unsigned LineSize  = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic [IndexBits-1:0] rd_index_i,
  output logic [TagBits-1:0]   rd_tag_o,
  output logic                 rd_valid_o,
  output logic [LineSize-1:0]  rd_data_o,
  input  logic                 we_i,
  input  logic [IndexBits-1:0] wr_index_i,
  input  logic [TagBits-1:0]   wr_tag_i,
  input  logic [LineSize-1:0]  wr_data_i
);

  logic [TagBits-1:0]  tag_q  [NbLines];
  logic [LineSize-1:0] data_q [NbLines];
  logic [NbLines-1:0]  valid_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  // Clear wins over a same-edge write so a flush also drops the line being filled.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache_dm_ctrl.sv
// Direct-mapped instruction cache controller: single-cycle hits, blocking line
// refill from DRAM, flush support and saturating hit/miss counters.
module icache_dm_ctrl #(
  parameter int unsigned ByteOffsetBits = icache_dm_ctrl_pkg::ByteOffsetBits,
  parameter int unsigned NB_LINES       = 16,
  localparam int unsigned NB_WORDS_LINE = icache_dm_ctrl_pkg::nb_words_line(ByteOffsetBits),
  localparam int unsigned LINE_SIZE     = icache_dm_ctrl_pkg::line_size(ByteOffsetBits)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic                 flush_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_valid_o,
  output logic                 cpu_stall_o,
  output logic [31:0]          mem_add_o,
  output logic                 mem_read_enable_o,
  input  logic                 mem_read_valid_i,
  input  logic [LINE_SIZE-1:0] mem_data_i,
  output logic [15:0]          hit_count_o,
  output logic [15:0]          miss_count_o
);

  import icache_dm_ctrl_pkg::*;

  localparam int unsigned INDEX_BITS = $clog2(NB_LINES);
  localparam int unsigned TAG_BITS   = 32 - INDEX_BITS - ByteOffsetBits;
  localparam int unsigned WORD_BITS  = ByteOffsetBits - 2;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [15:0]          hit_cnt_q, miss_cnt_q;
  logic [LINE_SIZE-1:0] line_q;

  logic [INDEX_BITS-1:0] req_index, fill_index;
  logic [TAG_BITS-1:0]   req_tag, fill_tag, rd_tag;
  logic [WORD_BITS-1:0]  word_sel;
  logic [LINE_SIZE-1:0]  rd_line;
  logic                  rd_valid, hit, miss, store_we, store_clear;

  assign req_index  = cpu_addr_i[ByteOffsetBits +: INDEX_BITS];
  assign req_tag    = cpu_addr_i[31 -: TAG_BITS];
  assign word_sel   = cpu_addr_i[2 +: WORD_BITS];
  assign fill_index = addr_q[ByteOffsetBits +: INDEX_BITS];
  assign fill_tag   = addr_q[31 -: TAG_BITS];

  assign hit  = !rst_i && (state_q == StIdle) && cpu_req_i && rd_valid && (rd_tag == req_tag);
  assign miss = !rst_i && (state_q == StIdle) && cpu_req_i && !hit;

  icache_line_store #(
    .NbLines  (NB_LINES),
    .IndexBits(INDEX_BITS),
    .TagBits  (TAG_BITS),
    .LineSize (LINE_SIZE)
  ) u_line_store (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (store_clear),
    .rd_index_i(req_index),
    .rd_tag_o  (rd_tag),
    .rd_valid_o(rd_valid),
    .rd_data_o (rd_line),
    .we_i      (store_we),
    .wr_index_i(fill_index),
    .wr_tag_i  (fill_tag),
    .wr_data_i (line_q)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q;
    store_we     = 1'b0;
    store_clear  = 1'b0;
    unique case (state_q)
      StIdle: begin
        store_clear = flush_i;
        if (miss) begin
          addr_d  = {cpu_addr_i[31:ByteOffsetBits], {ByteOffsetBits{1'b0}}};
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (flush_i) flush_pend_d = 1'b1;
        if (mem_read_valid_i) state_d = StUpdate;
      end
      StUpdate: begin
        store_we     = 1'b1;
        store_clear  = flush_pend_q || flush_i;
        flush_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
      if (hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == StRefill && mem_read_valid_i) line_q <= mem_data_i;
  end

  assign cpu_valid_o       = hit;
  assign cpu_data_o        = hit ? rd_line[32*word_sel +: 32] : 32'h0;
  assign cpu_stall_o       = !rst_i && (miss || state_q != StIdle);
  assign mem_read_enable_o = !rst_i && (state_q == StRefill);
  assign mem_add_o         = mem_read_enable_o ? addr_q : 32'h0;
  assign hit_count_o       = rst_i ? 16'h0 : hit_cnt_q;
  assign miss_count_o      = rst_i ? 16'h0 : miss_cnt_q;

endmodule

// File: tb/tb_icache_dm_ctrl.sv
// Self-checking bench for icache_dm_ctrl with a fixed-latency DRAM model whose
// words equal their byte addresses.
module tb_icache_dm_ctrl;
  import icache_dm_ctrl_pkg::*;

  localparam int unsigned Latency = 10;
  localparam int unsigned Lsz     = line_size(ByteOffsetBits);

  logic           clk = 1'b0;
  logic           rst, cpu_req, flush, inject_valid;
  logic [31:0]    cpu_addr;
  logic [31:0]    cpu_data, mem_add;
  logic           cpu_valid, cpu_stall, mem_read_enable, mem_read_valid, model_valid;
  logic [Lsz-1:0] mem_data;
  logic [15:0]    hit_count, miss_count;

  int errors = 0;
  int checks = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int unsigned lat_cnt;

  always #5 clk = ~clk;

  icache_dm_ctrl dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cpu_req_i        (cpu_req),
    .cpu_addr_i       (cpu_addr),
    .flush_i          (flush),
    .cpu_data_o       (cpu_data),
    .cpu_valid_o      (cpu_valid),
    .cpu_stall_o      (cpu_stall),
    .mem_add_o        (mem_add),
    .mem_read_enable_o(mem_read_enable),
    .mem_read_valid_i (mem_read_valid),
    .mem_data_i       (mem_data),
    .hit_count_o      (hit_count),
    .miss_count_o     (miss_count)
  );

  // DRAM: valid on the Latency-th cycle of a held read request.
  assign model_valid    = mem_read_enable && (lat_cnt == Latency - 1);
  assign mem_read_valid = model_valid || inject_valid;

  always_ff @(posedge clk) begin
    if (!mem_read_enable || model_valid) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
  end

  always_comb begin
    mem_data = '0;
    for (int i = 0; i < int'(Lsz / 32); i++) mem_data[32*i +: 32] = mem_add + 32'(4 * i);
  end

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic check1(input string nm, input logic got, input logic exp);
    check(nm, {31'h0, got}, {31'h0, exp});
  endtask

  task automatic check_counts(input string nm);
    check({nm, " hit_count"}, {16'h0, hit_count}, 32'(exp_hits));
    check({nm, " miss_count"}, {16'h0, miss_count}, 32'(exp_misses));
  endtask

  // Entered and left at posedge+1; samples at posedge+3.
  task automatic apply(input vec_t v, input int idx);
    cpu_req  = v.req;
    cpu_addr = v.addr;
    flush    = v.flush;
    #2;
    check1($sformatf("vec%0d valid", idx), cpu_valid, v.exp_valid);
    check($sformatf("vec%0d data", idx), cpu_data, v.exp_data);
    check1($sformatf("vec%0d stall", idx), cpu_stall, 1'b0);
    if (v.exp_valid) exp_hits++;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    flush   = 1'b0;
    check_counts($sformatf("vec%0d", idx));
  endtask

  task automatic do_miss(input logic [31:0] addr, input string nm);
    int   cyc;
    int   en_cycles;
    logic addr_ok;
    cpu_req  = 1'b1;
    cpu_addr = addr;
    #2;
    check1({nm, " stall on miss"}, cpu_stall, 1'b1);
    cyc = 0;
    en_cycles = 0;
    addr_ok = 1'b1;
    while (!cpu_valid && cyc < 100) begin
      if (mem_read_enable) begin
        en_cycles++;
        if (mem_add != {addr[31:5], 5'b0}) addr_ok = 1'b0;
      end
      @(posedge clk);
      #3;
      cyc++;
    end
    check({nm, " miss-to-hit cycles"}, 32'(cyc), 32'(Latency + 2));
    check({nm, " read enable cycles"}, 32'(en_cycles), 32'(Latency));
    check1({nm, " mem_add held"}, addr_ok, 1'b1);
    check({nm, " data"}, cpu_data, {addr[31:2], 2'b00});
    exp_misses++;
    exp_hits++;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    check_counts(nm);
  endtask

  initial begin
    int cyc;
    int bad;

    vecs[0]  = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h44};
    vecs[1]  = '{1'b1, 32'h48, 1'b0, 1'b1, 32'h48};
    vecs[2]  = '{1'b1, 32'h4C, 1'b0, 1'b1, 32'h4C};
    vecs[3]  = '{1'b1, 32'h50, 1'b0, 1'b1, 32'h50};
    vecs[4]  = '{1'b1, 32'h54, 1'b0, 1'b1, 32'h54};
    vecs[5]  = '{1'b1, 32'h58, 1'b0, 1'b1, 32'h58};
    vecs[6]  = '{1'b1, 32'h5C, 1'b0, 1'b1, 32'h5C};
    vecs[7]  = '{1'b0, 32'h240, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h4B, 1'b0, 1'b1, 32'h48};
    vecs[9]  = '{1'b0, 32'h80, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h5F, 1'b0, 1'b1, 32'h5C};

    rst = 1'b1;
    cpu_req = 1'b1;
    cpu_addr = 32'h40;
    flush = 1'b0;
    inject_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    check1("reset stall", cpu_stall, 1'b0);
    check1("reset valid", cpu_valid, 1'b0);
    check("reset data", cpu_data, 32'h0);
    check1("reset read enable", mem_read_enable, 1'b0);
    check("reset mem_add", mem_add, 32'h0);
    check_counts("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;

    do_miss(32'h40, "cold 0x40");

    for (int i = 0; i < 11; i++) begin
      apply(vecs[i], i);
      if (i == 6) check("hits after line walk", {16'h0, hit_count}, 32'd8);
    end

    do_miss(32'h240, "conflict 0x240");
    do_miss(32'h40, "evicted 0x40");

    // Flush pulsed mid-refill: line is filled then dropped, so the held request refills again.
    cpu_req = 1'b1;
    cpu_addr = 32'h80;
    cyc = 0;
    #2;
    while (!cpu_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      flush = (cyc == 3);
      #2;
      if (cyc == int'(Latency + 2)) begin
        check1("flush refill rehit valid", cpu_valid, 1'b0);
        check1("flush refill rehit stall", cpu_stall, 1'b1);
      end
    end
    check("flush refill total cycles", 32'(cyc), 32'(2 * (Latency + 2)));
    check("flush refill data", cpu_data, 32'h80);
    exp_misses += 2;
    exp_hits++;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    check_counts("flush refill");

    apply('{1'b1, 32'h80, 1'b1, 1'b1, 32'h80}, 11);
    do_miss(32'h80, "after idle flush 0x80");

    // Reset in the fifth refill cycle.
    cpu_req = 1'b1;
    cpu_addr = 32'h100;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
    end
    check1("refill5 read enable", mem_read_enable, 1'b1);
    rst = 1'b1;
    #2;
    check1("reset in refill enable", mem_read_enable, 1'b0);
    check1("reset in refill stall", cpu_stall, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_req = 1'b0;
    inject_valid = 1'b1;
    #2;
    check1("after reset enable", mem_read_enable, 1'b0);
    check1("late valid stall", cpu_stall, 1'b0);
    check1("late valid cpu_valid", cpu_valid, 1'b0);
    exp_hits = 0;
    exp_misses = 0;
    @(posedge clk);
    #1;
    inject_valid = 1'b0;
    check_counts("after reset");
    do_miss(32'h80, "post-reset 0x80");

    // Saturation: hold a hitting request until the hit counter tops out.
    cpu_req = 1'b1;
    cpu_addr = 32'h84;
    bad = 0;
    for (int n = 0; n < 65534; n++) begin
      #2;
      if (!cpu_valid) bad++;
      @(posedge clk);
      #1;
    end
    check("hit count at max", {16'h0, hit_count}, 32'hFFFF);
    #2;
    check1("saturating hit valid", cpu_valid, 1'b1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    check("hit count saturated", {16'h0, hit_count}, 32'hFFFF);
    check("miss count during hits", {16'h0, miss_count}, 32'd1);
    check("non-hit cycles in hold", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
